// File: rtl/vp_stream_switch.sv
// Frame-boundary stream selector with line padding for the VP output path.
// One of NUM_CH streams is routed to a registered output; short lines are padded to cfg_h_disp.
module vp_stream_switch #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 24,
  parameter int X_W     = 11,
  parameter int FRAME_W = 16,
  parameter int WDOG_W  = 24,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         cfg_sel,
  input  logic                     cfg_fill_en,
  input  logic [DATA_W-1:0]        cfg_fill_color,
  input  logic [X_W-1:0]           cfg_h_disp,
  input  logic                     stat_clr,
  input  logic [NUM_CH-1:0]        in_vs,
  input  logic [NUM_CH-1:0]        in_de,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_vs,
  output logic                     out_de,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         stat_active_sel,
  output logic [X_W-1:0]           stat_line_len,
  output logic [FRAME_W-1:0]       stat_frame_cnt,
  output logic                     stat_pad_ovr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [X_W-1:0]      x_cnt;
  logic [X_W-1:0]      x_nxt;
  logic [X_W-1:0]      x_inc;
  logic [X_W:0]        x_p1;
  logic                pad_last;
  logic                vs_q;
  logic [WDOG_W-1:0]   wdog;

  logic                cur_vs;
  logic                cur_de;
  logic [DATA_W-1:0]   cur_data;
  logic                sel_ok;
  logic                vs_rise;
  logic                wdog_fire;
  logic                sel_load;
  logic                ch_switch;

  logic                de_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                len_load;
  logic                ovr_set;

  assign cur_vs   = in_vs[stat_active_sel];
  assign cur_de   = in_de[stat_active_sel];
  assign cur_data = in_data[int'(stat_active_sel)*DATA_W +: DATA_W];

  assign sel_ok    = int'(cfg_sel) < NUM_CH;
  assign vs_rise   = cur_vs & ~vs_q;
  assign wdog_fire = (wdog == '1) & ~vs_rise;
  assign sel_load  = (vs_rise | wdog_fire) & sel_ok;
  assign ch_switch = sel_load & (cfg_sel != stat_active_sel);

  // x_p1 is one bit wider so the end-of-pad test still holds if cfg_h_disp drops below x_cnt.
  assign x_p1     = {1'b0, x_cnt} + (X_W+1)'(1);
  assign pad_last = x_p1 >= {1'b0, cfg_h_disp};
  assign x_inc    = (x_cnt == '1) ? x_cnt : x_p1[X_W-1:0];

  always_comb begin
    state_nxt = state;
    x_nxt     = x_cnt;
    de_nxt    = cur_de;
    data_nxt  = cur_de ? cur_data : '0;
    len_load  = 1'b0;
    ovr_set   = 1'b0;

    case (state)
      IDLE: begin
        if (cur_de) begin
          state_nxt = LINE;
          x_nxt     = X_W'(1);
        end
      end

      LINE: begin
        if (cur_de) begin
          x_nxt = x_inc;
        end else begin
          len_load = 1'b1;
          // The de-fall cycle already carries the first fill pixel so the padded line stays contiguous.
          if (cfg_fill_en && (x_cnt < cfg_h_disp)) begin
            de_nxt   = 1'b1;
            data_nxt = cfg_fill_color;
            if (pad_last) begin
              state_nxt = IDLE;
              x_nxt     = '0;
            end else begin
              state_nxt = PAD;
              x_nxt     = x_p1[X_W-1:0];
            end
          end else begin
            state_nxt = IDLE;
            x_nxt     = '0;
          end
        end
      end

      PAD: begin
        if (cur_de) begin
          ovr_set   = 1'b1;
          state_nxt = LINE;
          x_nxt     = X_W'(1);
        end else if (vs_rise) begin
          ovr_set   = 1'b1;
          state_nxt = IDLE;
          x_nxt     = '0;
        end else if (!cfg_fill_en) begin
          state_nxt = IDLE;
          x_nxt     = '0;
        end else begin
          de_nxt   = 1'b1;
          data_nxt = cfg_fill_color;
          if (pad_last) begin
            state_nxt = IDLE;
            x_nxt     = '0;
          end else begin
            x_nxt = x_p1[X_W-1:0];
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        x_nxt     = '0;
      end
    endcase

    if (ch_switch) begin
      state_nxt = IDLE;
      x_nxt     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      x_cnt    <= '0;
      vs_q     <= 1'b0;
      out_vs   <= 1'b0;
      out_de   <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      x_cnt    <= x_nxt;
      vs_q     <= cur_vs;
      out_vs   <= cur_vs;
      out_de   <= de_nxt;
      out_data <= data_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_active_sel <= '0;
      wdog            <= '0;
    end else begin
      if (sel_load) begin
        stat_active_sel <= cfg_sel;
      end
      if (vs_rise || wdog_fire) begin
        wdog <= '0;
      end else begin
        wdog <= wdog + WDOG_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_line_len  <= '0;
      stat_frame_cnt <= '0;
      stat_pad_ovr   <= 1'b0;
    end else begin
      if (len_load) begin
        stat_line_len <= x_cnt;
      end
      if (stat_clr) begin
        stat_frame_cnt <= vs_rise ? FRAME_W'(1) : '0;
      end else if (vs_rise) begin
        stat_frame_cnt <= stat_frame_cnt + FRAME_W'(1);
      end
      if (ovr_set) begin
        stat_pad_ovr <= 1'b1;
      end else if (stat_clr) begin
        stat_pad_ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vp_stream_switch.sv
// Scoreboard bench for vp_stream_switch: expected output beats are queued as stimulus is driven.
module tb_vp_stream_switch;

  localparam int NCH = 3;
  localparam int DW  = 24;
  localparam int XW  = 11;
  localparam int FW  = 16;
  localparam int WW  = 8;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SW-1:0]     cfg_sel;
  logic              cfg_fill_en;
  logic [DW-1:0]     cfg_fill_color;
  logic [XW-1:0]     cfg_h_disp;
  logic              stat_clr;
  logic [NCH-1:0]    in_vs;
  logic [NCH-1:0]    in_de;
  logic [NCH*DW-1:0] in_data;
  logic              out_vs;
  logic              out_de;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     stat_active_sel;
  logic [XW-1:0]     stat_line_len;
  logic [FW-1:0]     stat_frame_cnt;
  logic              stat_pad_ovr;

  always #5 clk = ~clk;

  vp_stream_switch #(
    .NUM_CH (NCH),
    .DATA_W (DW),
    .X_W    (XW),
    .FRAME_W(FW),
    .WDOG_W (WW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_sel        (cfg_sel),
    .cfg_fill_en    (cfg_fill_en),
    .cfg_fill_color (cfg_fill_color),
    .cfg_h_disp     (cfg_h_disp),
    .stat_clr       (stat_clr),
    .in_vs          (in_vs),
    .in_de          (in_de),
    .in_data        (in_data),
    .out_vs         (out_vs),
    .out_de         (out_de),
    .out_data       (out_data),
    .stat_active_sel(stat_active_sel),
    .stat_line_len  (stat_line_len),
    .stat_frame_cnt (stat_frame_cnt),
    .stat_pad_ovr   (stat_pad_ovr)
  );

  logic [DW+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int exp_sel = 0;
  int exp_frames = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] chan_px(input int k, input int x);
    logic [7:0]  id;
    logic [15:0] pos;
    id  = 8'(k + 1);
    pos = 16'(x);
    return {id, pos};
  endfunction

  task automatic step(input logic [NCH-1:0] vs, input logic [NCH-1:0] de, input int x,
                      input logic e_vs, input logic e_de, input logic [DW-1:0] e_data);
    logic [DW+1:0] exp;
    in_vs = vs;
    in_de = de;
    for (int k = 0; k < NCH; k++) in_data[k*DW +: DW] = chan_px(k, x);
    exp_q.push_back({e_vs, e_de, e_data});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check($sformatf("out@x%0d", x), 64'({out_vs, out_de, out_data}), 64'(exp));
  endtask

  task automatic line(input int npix, input int blank);
    for (int i = 0; i < npix; i++)
      step('0, '1, i, 1'b0, 1'b1, chan_px(exp_sel, i));
    for (int j = 0; j < blank; j++) begin
      if (cfg_fill_en && (npix + j) < int'(cfg_h_disp))
        step('0, '0, npix + j, 1'b0, 1'b1, cfg_fill_color);
      else
        step('0, '0, npix + j, 1'b0, 1'b0, '0);
    end
  endtask

  task automatic vs_pulse(input int len, input bit clr);
    for (int i = 0; i < len; i++) begin
      stat_clr = clr && (i == 0);
      step('1, '0, 0, 1'b1, 1'b0, '0);
      stat_clr = 1'b0;
      if (i == 0) begin
        exp_frames = clr ? 1 : exp_frames + 1;
        if (int'(cfg_sel) < NCH) exp_sel = int'(cfg_sel);
      end
    end
    step('0, '0, 0, 1'b0, 1'b0, '0);
    step('0, '0, 0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_stats(input string tag, input int len, input bit ovr);
    check({tag, " line_len"}, 64'(stat_line_len), 64'(len));
    check({tag, " pad_ovr"}, 64'(stat_pad_ovr), 64'(ovr));
    check({tag, " frame_cnt"}, 64'(stat_frame_cnt), 64'(exp_frames));
    check({tag, " active_sel"}, 64'(stat_active_sel), 64'(exp_sel));
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_sel = '0;
    cfg_fill_en = 1'b0;
    cfg_fill_color = '0;
    cfg_h_disp = '0;
    stat_clr = 1'b0;
    in_vs = '0;
    in_de = '0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out", 64'({out_vs, out_de, out_data}), 64'(0));
    check_stats("rst", 0, 1'b0);
    #2 rst_n = 1'b1;

    // passthrough: line width equals h_disp, nothing padded
    cfg_fill_en = 1'b1;
    cfg_h_disp = 11'd1280;
    cfg_fill_color = 24'h00FF00;
    vs_pulse(3, 1'b0);
    line(1280, 40);
    line(1280, 40);
    check_stats("pass", 1280, 1'b0);

    // padding 640 -> 1280 with long blanking
    vs_pulse(3, 1'b0);
    line(640, 800);
    line(640, 800);
    check_stats("pad", 640, 1'b0);

    // overrun: next line arrives after 100 fill pixels
    line(640, 100);
    line(640, 100);
    line(640, 700);
    check_stats("ovr", 640, 1'b1);
    stat_clr = 1'b1;
    step('0, '0, 0, 1'b0, 1'b0, '0);
    stat_clr = 1'b0;
    exp_frames = 0;
    check_stats("clr", 640, 1'b0);
    vs_pulse(3, 1'b1);
    check_stats("clr+vs", 640, 1'b0);

    // boundaries: one fill pixel, partial pad, exact width, saturation
    cfg_h_disp = 11'd16;
    line(15, 5);
    check_stats("hd-1", 15, 1'b0);
    line(10, 10);
    line(16, 4);
    check_stats("hd", 16, 1'b0);
    cfg_fill_en = 1'b0;
    line(2100, 5);
    check_stats("sat", 2047, 1'b0);

    // frame-boundary switching and invalid select
    cfg_h_disp = '0;
    vs_pulse(3, 1'b0);
    cfg_sel = 2'd2;
    line(20, 20);
    check_stats("pre-sw", 20, 1'b0);
    vs_pulse(3, 1'b0);
    check_stats("sw", 20, 1'b0);
    line(20, 20);
    cfg_sel = 2'd3;
    vs_pulse(3, 1'b0);
    check_stats("bad-sel", 20, 1'b0);
    for (int i = 0; i < 5; i++)
      step('0, '1, i, 1'b0, 1'b1, chan_px(exp_sel, i));

    // asynchronous reset in the middle of a line
    #2 rst_n = 1'b0;
    in_de = '0;
    #1;
    exp_sel = 0;
    exp_frames = 0;
    check("midrst out", 64'({out_vs, out_de, out_data}), 64'(0));
    check_stats("midrst", 0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cfg_sel = '0;
    line(30, 30);
    check_stats("post-rst", 30, 1'b0);

    // watchdog: vs stays low after one rise, request channel 1
    step('1, '0, 0, 1'b1, 1'b0, '0);
    exp_frames++;
    cfg_sel = 2'd1;
    for (int i = 1; i <= 256; i++) begin
      step('0, '0, 0, 1'b0, 1'b0, '0);
      if (i == 255) check("wdog early", 64'(stat_active_sel), 64'(0));
      if (i == 256) check("wdog fire", 64'(stat_active_sel), 64'(1));
    end
    exp_sel = 1;
    check("wdog frame_cnt", 64'(stat_frame_cnt), 64'(exp_frames));
    line(10, 10);
    check_stats("wdog", 10, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
